// File: rtl/load_arbiter.sv
// rtl/load_arbiter.sv - load uop arbiter between the AGU and external load sources
//
// load_arbiter_pkg: load uop types shared by the arbiter and its neighbours.
//
// load_arbiter: picks one load per cycle from the AGU and NUM_EXT external
// sources (page walker, prefetcher, ...) into a one-entry output register.
// The AGU has priority. An aging counter forces an external grant after
// AGE_LIMIT consecutive lost cycles. External sources share round-robin.
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   IN_aguLd       in   AGU load candidate (qualified by .valid)
//   OUT_aguLdStall out  AGU load not accepted this cycle
//   IN_extLd       in   external load candidates (qualified by .valid)
//   OUT_extLdStall out  per-source not-accepted flags
//   IN_ldUOpStall  in   downstream cannot take OUT_ldUOp this cycle
//   OUT_ldUOp      out  registered selected load
//   OUT_extIdx     out  external source index of OUT_ldUOp

package load_arbiter_pkg;

  typedef enum logic [3:0] {
    AGU_NO_EXCEPTION  = 4'd0,
    AGU_ADDR_MISALIGN = 4'd1,
    AGU_ACCESS_FAULT  = 4'd2,
    AGU_PAGE_FAULT    = 4'd3
  } AGU_Exception;

  typedef struct packed {
    logic [31:0]  addr;
    logic         signExtend;
    logic [1:0]   size;
    logic [6:0]   tagDst;
    logic [5:0]   sqN;
    logic         doNotCommit;
    logic         external;
    AGU_Exception exception;
    logic         isMMIO;
    logic         valid;
  } LD_UOp;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } PW_LD_UOp;

endpackage

module load_arbiter
  import load_arbiter_pkg::*;
#(
  parameter int         NUM_EXT   = 2,
  parameter int         AGE_LIMIT = 8,
  parameter logic [6:0] EXT_TAG   = 7'h40,
  localparam int        IDX_W     = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  LD_UOp                       IN_aguLd,
  output logic                        OUT_aguLdStall,
  input  PW_LD_UOp [NUM_EXT-1:0]      IN_extLd,
  output logic     [NUM_EXT-1:0]      OUT_extLdStall,
  input  logic                        IN_ldUOpStall,
  output LD_UOp                       OUT_ldUOp,
  output logic     [IDX_W-1:0]        OUT_extIdx
);

  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);

  logic [7:0]         ageCnt;
  logic [IDX_W-1:0]   rrPtr;

  logic [NUM_EXT-1:0] extValid;
  logic               anyExt;
  logic               free;
  logic               forceExt;
  logic               grantAgu;
  logic               grantExt;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickFound;
  logic [IDX_W-1:0]   nextRr;
  int                 scanIdx;
  LD_UOp              nextLd;

  always_comb begin
    for (int i = 0; i < NUM_EXT; i++) begin
      extValid[i] = IN_extLd[i].valid;
    end
  end

  assign anyExt = |extValid;
  // The register only accepts when empty or draining; IN_ldUOpStall never
  // reaches the data path, only this enable.
  assign free   = !OUT_ldUOp.valid || !IN_ldUOpStall;

  // Round-robin scan: first valid source at or after rrPtr, wrapping.
  always_comb begin
    pickIdx   = '0;
    pickFound = 1'b0;
    scanIdx   = 0;
    for (int off = 0; off < NUM_EXT; off++) begin
      scanIdx = int'(rrPtr) + off;
      if (scanIdx >= NUM_EXT) scanIdx = scanIdx - NUM_EXT;
      if (!pickFound && extValid[IDX_W'(scanIdx)]) begin
        pickFound = 1'b1;
        pickIdx   = IDX_W'(scanIdx);
      end
    end
  end

  assign nextRr = (pickIdx == IDX_W'(NUM_EXT - 1)) ? '0 : pickIdx + 1'b1;

  // Grant decision as if the register were free; stalls mask it when not.
  assign forceExt = (ageCnt == AGE_MAX) && anyExt;
  assign grantAgu = IN_aguLd.valid && !forceExt;
  assign grantExt = anyExt && !grantAgu;

  always_comb begin
    OUT_aguLdStall = IN_aguLd.valid;
    OUT_extLdStall = extValid;
    if (free) begin
      OUT_aguLdStall = IN_aguLd.valid && !grantAgu;
      for (int i = 0; i < NUM_EXT; i++) begin
        OUT_extLdStall[i] = extValid[i] && !(grantExt && (pickIdx == IDX_W'(i)));
      end
    end
  end

  always_comb begin
    nextLd          = IN_aguLd;
    nextLd.external = 1'b0;
    nextLd.valid    = 1'b1;
    if (!grantAgu) begin
      nextLd             = '0;
      nextLd.addr        = IN_extLd[pickIdx].addr;
      nextLd.size        = 2'd2;
      nextLd.tagDst      = EXT_TAG;
      nextLd.doNotCommit = 1'b1;
      nextLd.external    = 1'b1;
      nextLd.exception   = AGU_NO_EXCEPTION;
      nextLd.valid       = grantExt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_ldUOp  <= '0;
      OUT_extIdx <= '0;
      ageCnt     <= '0;
      rrPtr      <= '0;
    end else begin
      if (free) begin
        OUT_ldUOp <= nextLd;
        if (grantExt) begin
          OUT_extIdx <= pickIdx;
          rrPtr      <= nextRr;
        end
      end
      // Age counts AGU wins that starved a waiting external source.
      if (!anyExt || (free && grantExt)) begin
        ageCnt <= '0;
      end else if (free && grantAgu && (ageCnt != AGE_MAX)) begin
        ageCnt <= ageCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_load_arbiter.sv
// tb/tb_load_arbiter.sv - directed self-checking bench for load_arbiter
module tb_load_arbiter;
  import load_arbiter_pkg::*;

  logic                  clk;
  logic                  rst;
  LD_UOp                 aguLd;
  logic                  aguStall;
  PW_LD_UOp [1:0]        extLd;
  logic     [1:0]        extStall;
  logic                  ldStall;
  LD_UOp                 outLd;
  logic     [0:0]        extIdx;

  int nAsserts;
  int nFails;

  load_arbiter #(.NUM_EXT(2), .AGE_LIMIT(8), .EXT_TAG(7'h40)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_aguLd       (aguLd),
    .OUT_aguLdStall (aguStall),
    .IN_extLd       (extLd),
    .OUT_extLdStall (extStall),
    .IN_ldUOpStall  (ldStall),
    .OUT_ldUOp      (outLd),
    .OUT_extIdx     (extIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    aguLd   = '0;
    extLd   = '0;
    ldStall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_agu(input logic [31:0] addr);
    aguLd            = '0;
    aguLd.addr       = addr;
    aguLd.signExtend = 1'b1;
    aguLd.size       = 2'd1;
    aguLd.tagDst     = 7'h03;
    aguLd.sqN        = 6'd5;
    aguLd.valid      = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    set_agu(32'h0000_1234);
    extLd[0].valid = 1'b1;
    extLd[0].addr  = 32'h5555_0000;
    #1;
    nAsserts++; if (outLd.valid !== 1'b0) begin nFails++; $display("FAIL reset_valid got %0b want 0", outLd.valid); end
    nAsserts++; if (extIdx !== 1'b0) begin nFails++; $display("FAIL reset_extIdx got %0d want 0", extIdx); end
    nAsserts++; if (dut.ageCnt !== 8'd0) begin nFails++; $display("FAIL reset_ageCnt got %0d want 0", dut.ageCnt); end
    nAsserts++; if (dut.rrPtr !== 1'b0) begin nFails++; $display("FAIL reset_rrPtr got %0d want 0", dut.rrPtr); end
    nAsserts++; if (aguStall !== 1'b0) begin nFails++; $display("FAIL reset_aguStall got %0b want 0", aguStall); end
    nAsserts++; if (extStall !== 2'b01) begin nFails++; $display("FAIL reset_extStall got %b want 01", extStall); end
    @(posedge clk); #1;
    nAsserts++; if (outLd.valid !== 1'b0) begin nFails++; $display("FAIL reset_hold_valid got %0b want 0", outLd.valid); end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_agu_priority();
    do_reset();
    set_agu(32'h0000_1234);
    extLd[0].valid = 1'b1;
    extLd[0].addr  = 32'h5555_0000;
    #1;
    nAsserts++; if (aguStall !== 1'b0) begin nFails++; $display("FAIL prio_aguStall got %0b want 0", aguStall); end
    nAsserts++; if (extStall !== 2'b01) begin nFails++; $display("FAIL prio_extStall got %b want 01", extStall); end
    @(posedge clk); #1;
    nAsserts++; if (outLd.valid !== 1'b1) begin nFails++; $display("FAIL prio_valid got %0b want 1", outLd.valid); end
    nAsserts++; if (outLd.addr !== 32'h0000_1234) begin nFails++; $display("FAIL prio_addr got %h want 00001234", outLd.addr); end
    nAsserts++; if (outLd.external !== 1'b0) begin nFails++; $display("FAIL prio_external got %0b want 0", outLd.external); end
    nAsserts++; if (outLd.sqN !== 6'd5 || outLd.tagDst !== 7'h03 || outLd.size !== 2'd1 || outLd.signExtend !== 1'b1)
      begin nFails++; $display("FAIL prio_fields got sqN=%0d tag=%h size=%0d sx=%0b want 5 03 1 1", outLd.sqN, outLd.tagDst, outLd.size, outLd.signExtend); end
    nAsserts++; if (dut.ageCnt !== 8'd1) begin nFails++; $display("FAIL prio_ageCnt got %0d want 1", dut.ageCnt); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    nAsserts++; if (outLd.valid !== 1'b0) begin nFails++; $display("FAIL idle_valid got %0b want 0", outLd.valid); end
    nAsserts++; if (dut.ageCnt !== 8'd0) begin nFails++; $display("FAIL idle_ageCnt got %0d want 0", dut.ageCnt); end
  endtask

  task automatic test_ext_single();
    do_reset();
    extLd[0].valid = 1'b1;
    extLd[0].addr  = 32'h8000_1000;
    #1;
    nAsserts++; if (extStall !== 2'b00 || aguStall !== 1'b0) begin nFails++; $display("FAIL ext_stall got ext=%b agu=%0b want 00 0", extStall, aguStall); end
    @(posedge clk); #1;
    nAsserts++; if (outLd.valid !== 1'b1 || outLd.addr !== 32'h8000_1000) begin nFails++; $display("FAIL ext_addr got v=%0b %h want 1 80001000", outLd.valid, outLd.addr); end
    nAsserts++; if (outLd.size !== 2'd2 || outLd.tagDst !== 7'h40 || outLd.doNotCommit !== 1'b1 || outLd.external !== 1'b1)
      begin nFails++; $display("FAIL ext_fields got size=%0d tag=%h dnc=%0b ext=%0b want 2 40 1 1", outLd.size, outLd.tagDst, outLd.doNotCommit, outLd.external); end
    nAsserts++; if (outLd.sqN !== 6'd0 || outLd.signExtend !== 1'b0 || outLd.isMMIO !== 1'b0 || outLd.exception !== AGU_NO_EXCEPTION)
      begin nFails++; $display("FAIL ext_zero_fields got sqN=%0d sx=%0b mmio=%0b exc=%0d want 0 0 0 0", outLd.sqN, outLd.signExtend, outLd.isMMIO, outLd.exception); end
    nAsserts++; if (extIdx !== 1'b0) begin nFails++; $display("FAIL ext_idx got %0d want 0", extIdx); end
    nAsserts++; if (dut.rrPtr !== 1'b1) begin nFails++; $display("FAIL ext_rrPtr got %0d want 1", dut.rrPtr); end
  endtask

  task automatic test_round_robin();
    logic       expK;
    logic [1:0] expStall;
    do_reset();
    extLd[0].valid = 1'b1;
    extLd[0].addr  = 32'hA000_0000;
    extLd[1].valid = 1'b1;
    extLd[1].addr  = 32'hB000_0000;
    #1;
    for (int c = 0; c < 4; c++) begin
      expK     = (c % 2 == 1);
      expStall = expK ? 2'b01 : 2'b10;
      nAsserts++; if (extStall !== expStall) begin nFails++; $display("FAIL rr_stall c=%0d got %b want %b", c, extStall, expStall); end
      @(posedge clk); #1;
      nAsserts++; if (extIdx !== expK || outLd.external !== 1'b1) begin nFails++; $display("FAIL rr_grant c=%0d got idx=%0d ext=%0b want %0d 1", c, extIdx, outLd.external, expK); end
      nAsserts++; if (outLd.addr !== (expK ? 32'hB000_0000 : 32'hA000_0000)) begin nFails++; $display("FAIL rr_addr c=%0d got %h", c, outLd.addr); end
      nAsserts++; if (dut.rrPtr !== ~expK) begin nFails++; $display("FAIL rr_ptr c=%0d got %0d want %0d", c, dut.rrPtr, ~expK); end
    end
  endtask

  task automatic test_aging();
    int   expAge;
    logic expExt;
    do_reset();
    set_agu(32'h0000_2000);
    extLd[1].valid = 1'b1;
    extLd[1].addr  = 32'hC000_0040;
    #1;
    for (int i = 0; i < 10; i++) begin
      expAge = (i <= 8) ? i : 0;
      expExt = (i == 8);
      nAsserts++; if (dut.ageCnt !== 8'(expAge)) begin nFails++; $display("FAIL age_cnt i=%0d got %0d want %0d", i, dut.ageCnt, expAge); end
      nAsserts++; if (aguStall !== expExt || extStall !== (expExt ? 2'b00 : 2'b10))
        begin nFails++; $display("FAIL age_stall i=%0d got agu=%0b ext=%b want %0b %b", i, aguStall, extStall, expExt, (expExt ? 2'b00 : 2'b10)); end
      @(posedge clk); #1;
      nAsserts++; if (outLd.valid !== 1'b1 || outLd.external !== expExt) begin nFails++; $display("FAIL age_grant i=%0d got v=%0b ext=%0b want 1 %0b", i, outLd.valid, outLd.external, expExt); end
      if (expExt) begin
        nAsserts++; if (extIdx !== 1'b1 || outLd.addr !== 32'hC000_0040) begin nFails++; $display("FAIL age_ext i=%0d got idx=%0d addr=%h want 1 c0000040", i, extIdx, outLd.addr); end
        nAsserts++; if (dut.rrPtr !== 1'b0) begin nFails++; $display("FAIL age_rrPtr got %0d want 0", dut.rrPtr); end
      end
    end
    nAsserts++; if (dut.ageCnt !== 8'd1) begin nFails++; $display("FAIL age_repeat got %0d want 1", dut.ageCnt); end
  endtask

  task automatic test_downstream_stall();
    do_reset();
    set_agu(32'h0000_00A0);
    @(posedge clk); #1;
    nAsserts++; if (outLd.valid !== 1'b1 || outLd.addr !== 32'h0000_00A0) begin nFails++; $display("FAIL ds_first got v=%0b %h want 1 000000a0", outLd.valid, outLd.addr); end
    ldStall = 1'b1;
    set_agu(32'h0000_00B0);
    #1;
    for (int c = 0; c < 3; c++) begin
      nAsserts++; if (aguStall !== 1'b1) begin nFails++; $display("FAIL ds_stall c=%0d got %0b want 1", c, aguStall); end
      @(posedge clk); #1;
      nAsserts++; if (outLd.valid !== 1'b1 || outLd.addr !== 32'h0000_00A0) begin nFails++; $display("FAIL ds_hold c=%0d got v=%0b %h want 1 000000a0", c, outLd.valid, outLd.addr); end
    end
    ldStall = 1'b0;
    #1;
    nAsserts++; if (aguStall !== 1'b0) begin nFails++; $display("FAIL ds_release got %0b want 0", aguStall); end
    @(posedge clk); #1;
    nAsserts++; if (outLd.addr !== 32'h0000_00B0) begin nFails++; $display("FAIL ds_next got %h want 000000b0", outLd.addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    extLd[0].valid = 1'b1;
    extLd[0].addr  = 32'h7000_0000;
    @(posedge clk); #1;
    @(negedge clk);
    set_agu(32'h0000_3000);
    repeat (5) @(posedge clk);
    #1;
    nAsserts++; if (dut.ageCnt !== 8'd5 || dut.rrPtr !== 1'b1 || outLd.valid !== 1'b1)
      begin nFails++; $display("FAIL mid_setup got age=%0d rr=%0d v=%0b want 5 1 1", dut.ageCnt, dut.rrPtr, outLd.valid); end
    #2;
    rst = 1'b0;
    #1;
    nAsserts++; if (outLd.valid !== 1'b0) begin nFails++; $display("FAIL mid_valid got %0b want 0", outLd.valid); end
    nAsserts++; if (dut.ageCnt !== 8'd0 || dut.rrPtr !== 1'b0 || extIdx !== 1'b0)
      begin nFails++; $display("FAIL mid_state got age=%0d rr=%0d idx=%0d want 0 0 0", dut.ageCnt, dut.rrPtr, extIdx); end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    test_reset();
    test_agu_priority();
    test_ext_single();
    test_round_robin();
    test_aging();
    test_downstream_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/load_arbiter.md
LOAD_ARBITER -- requirements
Module: load_arbiter

Interface
REQ-001 Parameter NUM_EXT, default 2: number of external load sources (page walker, prefetcher, ...); range 1..8.
REQ-002 Parameter AGE_LIMIT, default 8: number of consecutive lost external cycles that forces an external grant; range 1..255.
REQ-003 Parameter EXT_TAG, default 7'h40: tagDst value driven for external loads.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 IN_aguLd  in  LD_UOp  AGU load candidate; qualified by .valid.
REQ-007 OUT_aguLdStall  out  1  AGU load not accepted this cycle.
REQ-008 IN_extLd  in  NUM_EXT x PW_LD_UOp  external load candidates; qualified by .valid.
REQ-009 OUT_extLdStall  out  NUM_EXT  per-source not-accepted flag.
REQ-010 IN_ldUOpStall  in  1  downstream cannot take OUT_ldUOp this cycle.
REQ-011 OUT_ldUOp  out  LD_UOp  registered selected load.
REQ-012 OUT_extIdx  out  max(1,$clog2(NUM_EXT))  index of the external source in OUT_ldUOp; valid only when OUT_ldUOp.valid and .external.

Function
REQ-013 Output register: OUT_ldUOp is a one-entry register; "free" = !OUT_ldUOp.valid || !IN_ldUOpStall.
REQ-014 When not free, register and OUT_extIdx hold; every valid source sees its stall asserted.
REQ-015 When free and no source valid, OUT_ldUOp.valid is 0 next cycle.
REQ-016 When free, exactly one valid source is granted; its stall is 0, all other valid sources see stall 1; invalid sources see stall 0.
REQ-017 Default priority: AGU wins over every external source.
REQ-018 Aging counter ageCnt (8 bit): increments by 1, saturating at AGE_LIMIT, in each free cycle where AGU is granted and at least one external source is valid.
REQ-019 ageCnt clears in any cycle an external source is granted, and in any cycle no external source is valid.
REQ-020 When free and ageCnt == AGE_LIMIT and an external source is valid, an external source wins over the AGU; AGU stalls.
REQ-021 Among external sources: round-robin pointer rrPtr; first valid index at or after rrPtr (wrapping modulo NUM_EXT) wins.
REQ-022 On an external grant of index k, rrPtr becomes (k+1) mod NUM_EXT; unchanged otherwise.
REQ-023 Granted AGU load: all LD_UOp fields copied from IN_aguLd; external = 0; valid = 1.
REQ-024 Granted external load: addr from source; signExtend 0; size 2; tagDst EXT_TAG; sqN 0; doNotCommit 1; external 1; exception AGU_NO_EXCEPTION; isMMIO 0; valid 1; OUT_extIdx = k.
REQ-025 Fields of OUT_ldUOp other than valid are don't-care while valid is 0.
REQ-026 Latency: source accepted in cycle N appears on OUT_ldUOp in cycle N+1; throughput one load per cycle when IN_ldUOpStall is 0.
REQ-027 Stall outputs are combinational from inputs and current state; no combinational path from IN_ldUOpStall to OUT_ldUOp.
REQ-028 Sources that deassert valid while stalled are simply dropped from arbitration; no state recorded.

Reset
REQ-029 While rst is 0: OUT_ldUOp.valid = 0, OUT_extIdx = 0, ageCnt = 0, rrPtr = 0, asynchronously.
REQ-030 Stall outputs during reset follow REQ-016 with register considered free.
REQ-031 Reset asserted mid-transfer discards the held load; no replay.

Verification
REQ-032 AGU and ext[0] valid, IN_ldUOpStall=0, NUM_EXT=2 -> AGU granted, OUT_aguLdStall=0, OUT_extLdStall=2'b01; next cycle OUT_ldUOp = AGU load, external=0.
REQ-033 ext[0] alone, addr 0x8000_1000 -> next cycle OUT_ldUOp.addr=0x8000_1000, size=2, tagDst=7'h40, doNotCommit=1, external=1, OUT_extIdx=0.
REQ-034 AGU and ext[1] valid continuously, AGE_LIMIT=8, no downstream stall -> 8 AGU grants, ext[1] granted on 9th cycle, ageCnt back to 0, pattern repeats.
REQ-035 ext[0] and ext[1] valid, AGU idle, 4 cycles -> grants 0,1,0,1; rrPtr toggles.
REQ-036 Output valid, IN_ldUOpStall=1 for 3 cycles with AGU valid -> OUT_ldUOp stable, OUT_aguLdStall=1 for 3 cycles; on release AGU accepted, appears next cycle.
REQ-037 rst pulled low with OUT_ldUOp.valid=1 and ageCnt=5 -> OUT_ldUOp.valid=0, ageCnt=0, rrPtr=0 immediately, without a clock edge.
